// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type and counter width for the memory responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} mem_state_e;
  localparam int LAT_W = 4;
endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - word register file: sync write, async read, sync active-low clear
module mem_resp_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < MEM_SIZE)) begin
      mem[waddr] <= wdata;
    end
  end

  // Unimplemented words read as zero so a stray address never indexes past the array.
  assign rdata = (32'(raddr) < MEM_SIZE) ? mem[raddr] : '0;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - storage endpoint: writes every cycle, reads after RD_LATENCY cycles
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  response,
  output logic                  error,
  output logic                  busy
);

  localparam logic [LAT_W-1:0]    LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  mem_state_e            state, state_d;
  logic [LAT_W-1:0]      cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] cap_addr, cap_addr_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  response_d, error_d;
  logic                  we;
  logic                  addr_ok;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  assign addr_ok = ({1'b0, addr} < MEM_LIMIT);
  assign rd_addr = (state == IDLE) ? addr : cap_addr;
  assign busy    = (state == RD_WAIT);

  mem_resp_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_array (
    .clk  (clk),
    .clr_n(reset),
    .we   (we),
    .waddr(addr),
    .wdata(wdata),
    .raddr(rd_addr),
    .rdata(rd_word)
  );

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    cap_addr_d = cap_addr;
    rdata_d    = rdata;
    response_d = 1'b0;
    error_d    = 1'b0;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (wr || rd) begin
          if ((wr && rd) || !addr_ok) begin
            response_d = 1'b1;
            error_d    = 1'b1;
          end else if (wr) begin
            we         = 1'b1;
            response_d = 1'b1;
          end else begin
            cap_addr_d = addr;
            // A one-cycle latency has no wait phase: data is latched on the accept edge.
            if (RD_LATENCY == 1) begin
              state_d    = RD_RESP;
              rdata_d    = rd_word;
              response_d = 1'b1;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = LAT_LOAD;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt == LAT_W'(1)) begin
          state_d    = RD_RESP;
          cnt_d      = '0;
          rdata_d    = rd_word;
          response_d = 1'b1;
        end else begin
          cnt_d = cnt - LAT_W'(1);
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      rdata    <= '0;
      response <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cap_addr <= cap_addr_d;
      rdata    <= rdata_d;
      response <= response_d;
      error    <= error_d;
    end
  end

endmodule
